clkdiv_pwm_multi: RTL and testbench

CLKDIV_PWM_MULTI -- requirements
Module: clkdiv_pwm_multi

---
 rtl/clkdiv_pkg.sv | 25 ++
 rtl/clkdiv_chan.sv | 108 ++++++++++
 rtl/clkdiv_pwm_multi.sv | 91 +++++++++
 tb/tb_clkdiv_pwm_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_pkg
// Purpose  : Shared types and helpers for the multi-channel clock divider /
//            PWM generator (channel state enum, channel-index width function).
// Ports    : none (package)
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    // Per-channel run state.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Width of a channel index; never below one bit so a single-channel
    // build still has a legal select port.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_chan.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_chan
// Purpose  : One divider/PWM channel: IDLE/RUN state, free-running period
//            counter, shadow and active period/duty registers, registered
//            clk_out and tick outputs.
// Ports    : clk_in, rst_n     - clock, asynchronous active-low reset
//            en                - run enable
//            sync              - force counter to 0 and apply shadows
//            wr_en             - accepted config write for this channel
//            wr_period/wr_duty - config data for the shadow registers
//            pending           - shadow holds a not-yet-applied write
//            clk_out, tick     - divided clock and wrap pulse
// Macros   : none (sync is tied low by the top when unused)
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int DEF_PERIOD = 750000,
    parameter int DEF_DUTY   = 250000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_period,
    input  logic [WIDTH-1:0] wr_duty,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEF_PERIOD);
    localparam logic [WIDTH-1:0] RST_DUTY   = WIDTH'(DEF_DUTY);

    chan_state_t      state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_duty;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            clk_out       <= 1'b0;
            tick          <= 1'b0;
            pending       <= 1'b0;
            active_period <= RST_PERIOD;
            active_duty   <= RST_DUTY;
            shadow_period <= RST_PERIOD;
            shadow_duty   <= RST_DUTY;
        end else begin
            state <= en ? RUN : IDLE;

            // Dropping en clears the outputs on the same edge the state
            // leaves RUN, so only RUN with en still high keeps counting.
            if (state == RUN && en) begin
                clk_out <= (count < active_duty);
                if (sync) begin
                    count <= '0;
                    tick  <= 1'b0;
                    if (pending) begin
                        active_period <= shadow_period;
                        active_duty   <= shadow_duty;
                        pending       <= 1'b0;
                    end
                end else if (count == active_period) begin
                    count <= '0;
                    tick  <= 1'b1;
                    // New settings only ever land on a period boundary.
                    if (pending) begin
                        active_period <= shadow_period;
                        active_duty   <= shadow_duty;
                        pending       <= 1'b0;
                    end
                end else begin
                    count <= count + 1'b1;
                    tick  <= 1'b0;
                end
            end else begin
                count   <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pending) begin
                    active_period <= shadow_period;
                    active_duty   <= shadow_duty;
                    pending       <= 1'b0;
                end
            end

            // A write is only accepted while pending is clear, so it never
            // collides with the apply above; one landing on a wrap edge
            // therefore waits for the following wrap.
            if (wr_en) begin
                shadow_period <= wr_period;
                shadow_duty   <= wr_duty;
                pending       <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clkdiv_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_pwm_multi
// Purpose  : CHANNELS independent clock dividers / PWM generators with a
//            valid/ready configuration port. Writes go to a per-channel
//            shadow and take effect at that channel's next period wrap.
// Ports    : clk_in, rst_n            - clock, asynchronous active-low reset
//            en[CHANNELS]             - per-channel run enable
//            sync (optional)          - restart all running channels
//            cfg_valid / cfg_ready    - config write handshake
//            cfg_ch, cfg_period, cfg_duty - target channel and new values
//            clk_out[CHANNELS]        - divided clock per channel
//            tick[CHANNELS]           - one-cycle wrap pulse per channel
// Macros   : CLKDIV_SYNC_EN - adds the sync input; absent by default
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_pwm_multi
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 20,
    parameter int DEF_PERIOD = 750000,
    parameter int DEF_DUTY   = 250000
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           en,
`ifdef CLKDIV_SYNC_EN
    input  logic                          sync,
`endif
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_idx_w(CHANNELS)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]              cfg_period,
    input  logic [WIDTH-1:0]              cfg_duty,
    output logic [CHANNELS-1:0]           clk_out,
    output logic [CHANNELS-1:0]           tick
);

    localparam int IDX_W = ch_idx_w(CHANNELS);

    logic [CHANNELS-1:0]     pending;
    logic [(1<<IDX_W)-1:0]   ready_vec;
    logic                    sync_all;

`ifdef CLKDIV_SYNC_EN
    assign sync_all = sync;
`else
    assign sync_all = 1'b0;
`endif

    // Ready table covers every encodable index; unused indices read as
    // ready so writes to them are swallowed.
    generate
        for (genvar i = 0; i < (1 << IDX_W); i++) begin : g_ready
            if (i < CHANNELS) begin : g_live
                assign ready_vec[i] = ~pending[i];
            end else begin : g_void
                assign ready_vec[i] = 1'b1;
            end
        end
    endgenerate

    assign cfg_ready = ready_vec[cfg_ch];

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            logic wr_en;
            assign wr_en = cfg_valid && cfg_ready && (cfg_ch == IDX_W'(i));

            clkdiv_chan #(
                .WIDTH      (WIDTH),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_DUTY   (DEF_DUTY)
            ) u_chan (
                .clk_in    (clk_in),
                .rst_n     (rst_n),
                .en        (en[i]),
                .sync      (sync_all),
                .wr_en     (wr_en),
                .wr_period (cfg_period),
                .wr_duty   (cfg_duty),
                .pending   (pending[i]),
                .clk_out   (clk_out[i]),
                .tick      (tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_pwm_multi
// Purpose  : Self-checking bench for clkdiv_pwm_multi (3 channels, 8-bit).
//            Expected per-edge clk_out/tick values are queued as stimulus is
//            applied and compared on the following falling edge.
//            Reset defaults 262/258 truncate to 6/2 in 8 bits.
// Macros   : CLKDIV_SYNC_EN - also exercises the sync input
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_pwm_multi;

    localparam int CH = 3;
    localparam int W  = 8;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_period;
    logic [W-1:0]  cfg_duty;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
    logic          sync;
`endif

    always #5 clk_in = ~clk_in;

    clkdiv_pwm_multi #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .DEF_PERIOD (262),
        .DEF_DUTY   (258)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
`ifdef CLKDIV_SYNC_EN
        .sync       (sync),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    typedef struct {
        string         tag;
        logic [CH-1:0] mask;
        logic [CH-1:0] clk;
        logic [CH-1:0] tk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void push(input string tag, input logic [CH-1:0] mask,
                                 input logic [CH-1:0] c, input logic [CH-1:0] t);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.clk  = c & mask;
        e.tk   = t & mask;
        sb.push_back(e);
    endfunction

    // Queue one expected entry per edge for reps full periods, starting at
    // count 0: high while count < duty, tick on the count == period edge.
    task automatic push_period(input string tag, input logic [CH-1:0] mask,
                               input int period, input int duty, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c <= period; c++) begin
                push(tag, mask, (c < duty) ? mask : '0, (c == period) ? mask : '0);
            end
        end
    endtask

    // Outputs are compared half a cycle after each active edge.
    always @(negedge clk_in) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_clk"},  clk_out & e.mask, e.clk);
            chk({e.tag, "_tick"}, tick & e.mask,    e.tk);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    // Holds valid across exactly one rising edge.
    task automatic cfg_write(input int ch, input int p, input int d);
        cfg_ch     = 2'(ch);
        cfg_period = W'(p);
        cfg_duty   = W'(d);
        cfg_valid  = 1'b1;
        step(1);
        cfg_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_duty = '0;
`ifdef CLKDIV_SYNC_EN
        sync = 1'b0;
`endif
        step(2);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        step(1);

        // Out-of-range channel: always ready, no channel takes the write.
        cfg_ch = 2'd3; cfg_period = 8'd1; cfg_duty = 8'd1; cfg_valid = 1'b1;
        #1 chk("oob_ready", cfg_ready, 1);
        step(1);
        cfg_valid = 1'b0;
        for (int c = 0; c < CH; c++) begin
            cfg_ch = 2'(c);
            #1 chk("oob_no_pending", cfg_ready, 1);
        end

        // ch0 period 3 duty 2 -> 1,1,0,0 with tick every 4th edge.
        cfg_write(0, 3, 2);
        chk("b_ready_pending", cfg_ready, 0);
        step(1);
        chk("b_ready_applied", cfg_ready, 1);
        en[0] = 1'b1;
        push("b_start", 3'b001, 0, 0);
        push_period("b_wave", 3'b001, 3, 2, 3);
        step(13);

        // Write 5/1 while count is 1: old period finishes first.
        push("c_pre", 3'b001, 3'b001, 0);
        step(1);
        push("c_old", 3'b001, 3'b001, 0);
        cfg_write(0, 5, 1);
        chk("c_ready_busy", cfg_ready, 0);
        push("c_old", 3'b001, 0, 0);
        push("c_old_wrap", 3'b001, 0, 3'b001);
        step(1);
        chk("c_ready_busy2", cfg_ready, 0);
        step(1);
        chk("c_ready_free", cfg_ready, 1);
        push_period("c_new", 3'b001, 5, 1, 2);
        step(12);
        en[0] = 1'b0;
        push("c_off", 3'b001, 0, 0);
        push("c_off", 3'b001, 0, 0);
        step(2);

        // ch2 edge cases: duty 0, duty > period, period 0.
        cfg_write(2, 3, 0);
        step(1);
        en[2] = 1'b1;
        push("d_start", 3'b100, 0, 0);
        push_period("d_duty0", 3'b100, 3, 0, 2);
        step(9);
        en[2] = 1'b0;
        cfg_write(2, 3, 10);
        step(1);
        en[2] = 1'b1;
        push("d_start", 3'b100, 0, 0);
        push_period("d_duty_big", 3'b100, 3, 10, 2);
        step(9);
        en[2] = 1'b0;
        cfg_write(2, 0, 1);
        step(1);
        en[2] = 1'b1;
        push("d_start", 3'b100, 0, 0);
        push_period("d_period0", 3'b100, 0, 1, 6);
        step(7);
        en[2] = 1'b0;
        step(1);

        // ch1 on reset defaults (6/2); drop en mid-period and restart.
        en[1] = 1'b1;
        push("e_start", 3'b010, 0, 0);
        push_period("e_def", 3'b010, 6, 2, 1);
        push("e_run", 3'b010, 3'b010, 0);
        push("e_run", 3'b010, 3'b010, 0);
        push("e_run", 3'b010, 0, 0);
        step(11);
        en[1] = 1'b0;
        push("e_drop", 3'b010, 0, 0);
        push("e_idle", 3'b010, 0, 0);
        step(2);
        en[1] = 1'b1;
        push("e_restart", 3'b010, 0, 0);
        push("e_restart", 3'b010, 3'b010, 0);
        step(2);

        // Leave a write pending on ch1, then reset between edges.
        push("f_pre", 3'b010, 3'b010, 0);
        cfg_write(1, 1, 1);
        chk("f_ready_busy", cfg_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("f_async_clk", clk_out, 0);
        chk("f_async_tick", tick, 0);
        chk("f_pending_drop", cfg_ready, 1);
        step(1);
        rst_n = 1'b1;
        en = 3'b110;
        push("f_start", 3'b110, 0, 0);
        push_period("f_defaults", 3'b110, 6, 2, 2);
        step(15);

`ifdef CLKDIV_SYNC_EN
        // Knock ch2 out of phase with ch1, then resynchronise both.
        en[2] = 1'b0;
        step(2);
        en[2] = 1'b1;
        step(4);
        sync = 1'b1;
        push("g_sync_edge", 3'b110, 0, 0);
        step(1);
        sync = 1'b0;
        push_period("g_aligned", 3'b110, 6, 2, 2);
        step(14);
`endif

        en = '0;
        step(2);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
